snoop_responder: RTL and testbench
==================================

Name: snoop_responder

Overview:
- Snoop-side responder of the L2 MESI protocol.
- Accepts one bus operation at a time from another processor and looks up the line state through the tag array's request/ack port.
- Produces the snoop result (NoHIT/HIT/HITM) that the initiating cache's MESI next-state logic consumes.
- Issues the dirty writeback, applies the MESI downgrade or invalidate to the line, and flags illegal protocol combinations.

Parameters:
- ADDR_W, 32, width of snooped physical address.
- WB_TIMEOUT, 16, maximum WRITEBACK cycles waiting for wb_done before abort (1..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- snoop_valid  in  1  bus operation offered
- snoop_op  in  3  1=READ, 2=WRITE, 3=INVALIDATE, 4=RWIM; others illegal
- snoop_addr  in  ADDR_W  snooped address
- snoop_ready  out  1  high only in IDLE; transfer when valid&&ready
- lookup_req  out  1  tag lookup request, held until lookup_ack
- lookup_addr  out  ADDR_W  latched snoop address
- lookup_ack  in  1  lookup complete; hit/state valid this cycle
- lookup_hit  in  1  tag match
- lookup_state  in  2  00=M, 01=E, 10=S, 11=I
- wb_req  out  1  writeback request, held until wb_done or timeout
- wb_addr  out  ADDR_W  latched snoop address
- wb_done  in  1  writeback accepted by bus
- update_en  out  1  one-cycle pulse, write update_state to line
- update_state  out  2  new MESI state
- result_valid  out  1  one-cycle pulse, snoop_result valid
- snoop_result  out  2  00=NoHIT, 01=HIT, 10=HITM
- err  out  1  one-cycle pulse on illegal op/state combination or wb timeout

Behaviour:
- Reset:
  - FSM returns to IDLE; all request and pulse outputs are 0.
  - snoop_result=00; update_state=11; counter=0; latched address=0.
  - Reset mid-operation abandons the transaction with no update_en and no result_valid.
- FSM states: IDLE -> LOOKUP -> DECIDE -> [WRITEBACK] -> UPDATE -> RESPOND -> IDLE.
- IDLE:
  - snoop_ready=1.
  - On snoop_valid, latch op and address, then go to LOOKUP.
- LOOKUP:
  - lookup_req=1 every cycle until lookup_ack.
  - On ack, latch hit and state, then go to DECIDE.
  - The lookup has no timeout.
- DECIDE (one cycle) applies this table; a miss or state I always gives NoHIT, no change, no error:
  - READ: M->S with HITM and writeback; E->S with HIT; S->S with HIT.
  - RWIM: M->I with HITM and writeback; E->I and S->I with NoHIT.
  - INVALIDATE: S->I with NoHIT; M or E gives err, state unchanged, NoHIT.
  - WRITE: any valid state gives err, state unchanged, NoHIT.
  - Illegal op code: err, NoHIT, no change.
- WRITEBACK:
  - wb_req=1 and the counter increments each cycle.
  - On wb_done, go to UPDATE.
  - If the counter reaches WB_TIMEOUT without wb_done, pulse err, suppress the state change, keep HITM, and go to UPDATE.
  - wb_done in the same cycle as the timeout counts as done.
- UPDATE:
  - update_en=1 only when the new state differs from the latched state.
  - update_state carries the new state and holds until the next UPDATE.
- RESPOND:
  - result_valid=1 for one cycle.
  - snoop_result holds its value until the next RESPOND.
- err timing: the err pulse occurs in the DECIDE cycle for protocol errors and in the timeout cycle for writebacks.
- Latency, with accept at cycle N and ack at N+1:
  - No writeback: update at N+3, result at N+4.
  - Writeback with wb_done at cycle W: update at W+1, result at W+2.
- Throughput is one transaction in flight; snoop_ready is low from N+1 until the cycle after RESPOND.
- Inputs lookup_ack and wb_done outside their states are ignored.

Test Plan:
- READ on line in E (ack at first LOOKUP cycle) -> update_en with update_state=10 at N+3; result_valid with snoop_result=01 at N+4; err=0.
- READ on M, wb_done 3 cycles after wb_req rises -> wb_req high exactly 3 cycles with wb_addr=snoop_addr; update_state=10; snoop_result=10.
- RWIM on S, then RWIM on M -> first gives update_state=11 and snoop_result=00 with no wb_req; second gives wb_req, update_state=11, snoop_result=10.
- INVALIDATE on E, WRITE on S, op=7 -> each gives an err pulse in DECIDE, no update_en, snoop_result=00.
- READ on M with wb_done never asserted, WB_TIMEOUT=4 -> wb_req high 4 cycles; err pulse; no update_en; snoop_result=10.
- Miss (lookup_hit=0) with lookup_ack delayed 5 cycles -> lookup_req high 5 cycles; snoop_result=00; no update. Reset asserted during LOOKUP -> next cycle snoop_ready=1 and no result_valid.

Source files
------------

// File: rtl/snoop_responder.sv
// Snoop-side MESI responder: looks up the snooped line, decides HIT/HITM/NoHIT,
// issues the dirty writeback, downgrades or invalidates the line and flags protocol errors.
module snoop_responder #(
   parameter int ADDR_W     = 32,
   parameter int WB_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              snoop_valid,
   input  logic [2:0]        snoop_op,
   input  logic [ADDR_W-1:0] snoop_addr,
   output logic              snoop_ready,
   output logic              lookup_req,
   output logic [ADDR_W-1:0] lookup_addr,
   input  logic              lookup_ack,
   input  logic              lookup_hit,
   input  logic [1:0]        lookup_state,
   output logic              wb_req,
   output logic [ADDR_W-1:0] wb_addr,
   input  logic              wb_done,
   output logic              update_en,
   output logic [1:0]        update_state,
   output logic              result_valid,
   output logic [1:0]        snoop_result,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOOKUP, S_DECIDE, S_WB, S_UPDATE, S_RESPOND
   } state_t;

   localparam logic [1:0] MESI_M = 2'b00, MESI_E = 2'b01, MESI_S = 2'b10, MESI_I = 2'b11;
   localparam logic [1:0] R_NOHIT = 2'b00, R_HIT = 2'b01, R_HITM = 2'b10;
   localparam logic [2:0] OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INV = 3'd3, OP_RWIM = 3'd4;
   localparam logic [7:0] WB_LAST = 8'(WB_TIMEOUT - 1);

   state_t            state_q;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        st_q, nst_q, res_q, upd_q, result_q;
   logic [7:0]        cnt_q;

   logic [1:0] nst_d, res_d;
   logic       wb_d, perr_d, wb_to;

   // Decision table; st_q already folds a miss into state I.
   always_comb begin
      nst_d  = st_q;
      res_d  = R_NOHIT;
      wb_d   = 1'b0;
      perr_d = 1'b0;
      if (st_q != MESI_I) begin
         case (op_q)
            OP_READ: begin
               nst_d = MESI_S;
               if (st_q == MESI_M) begin
                  res_d = R_HITM;
                  wb_d  = 1'b1;
               end else begin
                  res_d = R_HIT;
               end
            end
            OP_RWIM: begin
               nst_d = MESI_I;
               if (st_q == MESI_M) begin
                  res_d = R_HITM;
                  wb_d  = 1'b1;
               end
            end
            OP_INV: begin
               if (st_q == MESI_S) nst_d = MESI_I;
               else                perr_d = 1'b1;
            end
            OP_WRITE: perr_d = 1'b1;
            default:  perr_d = 1'b1;
         endcase
      end
   end

   // wb_done on the last allowed cycle wins over the timeout.
   assign wb_to = (state_q == S_WB) && !wb_done && (cnt_q == WB_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= 3'd0;
         addr_q   <= '0;
         st_q     <= MESI_I;
         nst_q    <= MESI_I;
         res_q    <= R_NOHIT;
         upd_q    <= MESI_I;
         result_q <= R_NOHIT;
         cnt_q    <= 8'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (snoop_valid) begin
                  op_q    <= snoop_op;
                  addr_q  <= snoop_addr;
                  state_q <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (lookup_ack) begin
                  st_q    <= lookup_hit ? lookup_state : MESI_I;
                  state_q <= S_DECIDE;
               end
            end
            S_DECIDE: begin
               nst_q <= nst_d;
               res_q <= res_d;
               cnt_q <= 8'd0;
               if (wb_d) begin
                  state_q <= S_WB;
               end else begin
                  upd_q   <= nst_d;
                  state_q <= S_UPDATE;
               end
            end
            S_WB: begin
               cnt_q <= cnt_q + 8'd1;
               if (wb_done) begin
                  upd_q   <= nst_q;
                  state_q <= S_UPDATE;
               end else if (wb_to) begin
                  upd_q   <= st_q;
                  state_q <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               result_q <= res_q;
               state_q  <= S_RESPOND;
            end
            S_RESPOND: state_q <= S_IDLE;
            default:   state_q <= S_IDLE;
         endcase
      end
   end

   assign snoop_ready  = (state_q == S_IDLE);
   assign lookup_req   = (state_q == S_LOOKUP);
   assign lookup_addr  = addr_q;
   assign wb_req       = (state_q == S_WB);
   assign wb_addr      = addr_q;
   assign update_en    = (state_q == S_UPDATE) && (upd_q != st_q);
   assign update_state = upd_q;
   assign result_valid = (state_q == S_RESPOND);
   assign snoop_result = result_q;
   assign err          = ((state_q == S_DECIDE) && perr_d) || wb_to;

endmodule

// File: tb/tb_snoop_responder.sv
// Directed bench for snoop_responder; a negedge monitor tallies output activity per transaction.
module tb_snoop_responder;
   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          snoop_valid = 1'b0;
   logic [2:0]    snoop_op = 3'd0;
   logic [AW-1:0] snoop_addr = '0;
   logic          snoop_ready, lookup_req, wb_req, update_en, result_valid, err;
   logic [AW-1:0] lookup_addr, wb_addr;
   logic          lookup_ack = 1'b0, lookup_hit = 1'b0, wb_done = 1'b0;
   logic [1:0]    lookup_state = 2'b11;
   logic [1:0]    update_state, snoop_result;

   snoop_responder #(.ADDR_W(AW), .WB_TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
      .snoop_ready(snoop_ready),
      .lookup_req(lookup_req), .lookup_addr(lookup_addr), .lookup_ack(lookup_ack),
      .lookup_hit(lookup_hit), .lookup_state(lookup_state),
      .wb_req(wb_req), .wb_addr(wb_addr), .wb_done(wb_done),
      .update_en(update_en), .update_state(update_state),
      .result_valid(result_valid), .snoop_result(snoop_result), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0, fails = 0;
   int acc;
   logic [AW-1:0] exp_addr;
   int lreq_cnt, wb_cnt, addr_bad, upd_cnt, upd_cyc, res_cnt, res_cyc, err_cnt, err_cyc, rdy_low;
   logic [1:0] upd_val, res_val;

   always @(negedge clk) begin
      if (!reset) begin
         if (lookup_req) begin
            lreq_cnt++;
            if (lookup_addr !== exp_addr) addr_bad++;
         end
         if (wb_req) begin
            wb_cnt++;
            if (wb_addr !== exp_addr) addr_bad++;
         end
         if (update_en) begin upd_cnt++; upd_cyc = cyc; upd_val = update_state; end
         if (result_valid) begin res_cnt++; res_cyc = cyc; res_val = snoop_result; end
         if (err) begin err_cnt++; err_cyc = cyc; end
         if (!snoop_ready) rdy_low++;
      end
   end

   task automatic clr();
      lreq_cnt = 0; wb_cnt = 0; addr_bad = 0; upd_cnt = 0; upd_cyc = -1;
      res_cnt = 0; res_cyc = -1; err_cnt = 0; err_cyc = -1; rdy_low = 0;
      upd_val = 2'bxx; res_val = 2'bxx;
   endtask

   // Offer one op, ack in the ack_d-th LOOKUP cycle, hold WB for wb_n cycles (0 = never done).
   task automatic run(input logic [2:0] op, input logic [AW-1:0] a, input logic hit,
                      input logic [1:0] st, input int ack_d, input int wb_n);
      clr();
      exp_addr = a;
      snoop_valid = 1'b1; snoop_op = op; snoop_addr = a;
      acc = cyc;
      @(posedge clk); #1;
      snoop_valid = 1'b0;
      for (int i = 1; i <= ack_d; i++) begin
         if (i == ack_d) begin lookup_ack = 1'b1; lookup_hit = hit; lookup_state = st; end
         @(posedge clk); #1;
         lookup_ack = 1'b0;
      end
      if (wb_n > 0) begin
         @(posedge clk); #1;
         for (int k = 1; k <= wb_n; k++) begin
            wb_done = (k == wb_n);
            @(posedge clk); #1;
         end
         wb_done = 1'b0;
      end
      for (int t = 0; t < 30 && res_cnt == 0; t++) begin
         @(posedge clk); #1;
      end
      tests++;
      if (res_cnt == 0) begin
         fails++; $display("FAIL wait_result: no result_valid within bound, op=%0d", op);
      end
   endtask

   task automatic test_reset();
      tests++; if (snoop_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b want 1", snoop_ready); end
      tests++; if ({lookup_req, wb_req, update_en, result_valid, err} !== 5'b0) begin
         fails++; $display("FAIL rst_pulses got %b want 00000", {lookup_req, wb_req, update_en, result_valid, err}); end
      tests++; if (snoop_result !== 2'b00) begin fails++; $display("FAIL rst_result got %b want 00", snoop_result); end
      tests++; if (update_state !== 2'b11) begin fails++; $display("FAIL rst_upd_state got %b want 11", update_state); end
      tests++; if (lookup_addr !== '0 || wb_addr !== '0) begin
         fails++; $display("FAIL rst_addr got %h/%h want 0", lookup_addr, wb_addr); end
   endtask

   task automatic test_read_e();
      run(3'd1, 32'h0000_1040, 1'b1, 2'b01, 1, 0);
      tests++; if (upd_cnt !== 1 || upd_cyc !== acc + 3 || upd_val !== 2'b10) begin
         fails++; $display("FAIL read_e_upd got cnt=%0d cyc=%0d st=%b want 1/%0d/10", upd_cnt, upd_cyc - acc, upd_val, 3); end
      tests++; if (res_cnt !== 1 || res_cyc !== acc + 4 || res_val !== 2'b01) begin
         fails++; $display("FAIL read_e_res got cnt=%0d cyc=%0d r=%b want 1/4/01", res_cnt, res_cyc - acc, res_val); end
      tests++; if (err_cnt !== 0 || wb_cnt !== 0 || lreq_cnt !== 1) begin
         fails++; $display("FAIL read_e_misc got err=%0d wb=%0d lreq=%0d want 0/0/1", err_cnt, wb_cnt, lreq_cnt); end
      tests++; if (rdy_low !== 4) begin fails++; $display("FAIL read_e_ready_low got %0d want 4", rdy_low); end
   endtask

   task automatic test_read_m_wb();
      run(3'd1, 32'hDEAD_BEE0, 1'b1, 2'b00, 1, 3);
      tests++; if (wb_cnt !== 3 || addr_bad !== 0) begin
         fails++; $display("FAIL rdm_wb got wb=%0d badaddr=%0d want 3/0", wb_cnt, addr_bad); end
      tests++; if (upd_cnt !== 1 || upd_cyc !== acc + 6 || upd_val !== 2'b10) begin
         fails++; $display("FAIL rdm_upd got cnt=%0d cyc=%0d st=%b want 1/6/10", upd_cnt, upd_cyc - acc, upd_val); end
      tests++; if (res_cyc !== acc + 7 || res_val !== 2'b10 || err_cnt !== 0) begin
         fails++; $display("FAIL rdm_res got cyc=%0d r=%b err=%0d want 7/10/0", res_cyc - acc, res_val, err_cnt); end
      repeat (2) @(posedge clk); #1;
      tests++; if (snoop_result !== 2'b10 || update_state !== 2'b10) begin
         fails++; $display("FAIL rdm_hold got r=%b st=%b want 10/10", snoop_result, update_state); end
   endtask

   task automatic test_rwim();
      run(3'd4, 32'h0000_2000, 1'b1, 2'b10, 1, 0);
      tests++; if (wb_cnt !== 0 || upd_cnt !== 1 || upd_val !== 2'b11 || res_val !== 2'b00) begin
         fails++; $display("FAIL rwim_s got wb=%0d upd=%0d st=%b r=%b want 0/1/11/00", wb_cnt, upd_cnt, upd_val, res_val); end
      run(3'd4, 32'h0000_3000, 1'b1, 2'b00, 2, 1);
      tests++; if (wb_cnt !== 1 || addr_bad !== 0 || upd_cnt !== 1 || upd_val !== 2'b11 || res_val !== 2'b10) begin
         fails++; $display("FAIL rwim_m got wb=%0d bad=%0d upd=%0d st=%b r=%b want 1/0/1/11/10",
                           wb_cnt, addr_bad, upd_cnt, upd_val, res_val); end
   endtask

   task automatic test_errors();
      logic [2:0] ops [3];
      logic [1:0] sts [3];
      ops[0] = 3'd3; sts[0] = 2'b01;
      ops[1] = 3'd2; sts[1] = 2'b10;
      ops[2] = 3'd7; sts[2] = 2'b01;
      for (int i = 0; i < 3; i++) begin
         run(ops[i], 32'h0000_4000 + i * 64, 1'b1, sts[i], 1, 0);
         tests++; if (err_cnt !== 1 || err_cyc !== acc + 2) begin
            fails++; $display("FAIL err_pulse op=%0d got cnt=%0d cyc=%0d want 1/2", ops[i], err_cnt, err_cyc - acc); end
         tests++; if (upd_cnt !== 0 || res_val !== 2'b00 || wb_cnt !== 0) begin
            fails++; $display("FAIL err_noupd op=%0d got upd=%0d r=%b wb=%0d want 0/00/0", ops[i], upd_cnt, res_val, wb_cnt); end
      end
   endtask

   task automatic test_wb_timeout();
      run(3'd1, 32'h0000_5000, 1'b1, 2'b00, 1, 0);
      tests++; if (wb_cnt !== 4) begin fails++; $display("FAIL to_wb got %0d want 4", wb_cnt); end
      tests++; if (err_cnt !== 1 || err_cyc !== acc + 6) begin
         fails++; $display("FAIL to_err got cnt=%0d cyc=%0d want 1/6", err_cnt, err_cyc - acc); end
      tests++; if (upd_cnt !== 0 || res_val !== 2'b10 || res_cyc !== acc + 8) begin
         fails++; $display("FAIL to_res got upd=%0d r=%b cyc=%0d want 0/10/8", upd_cnt, res_val, res_cyc - acc); end
   endtask

   task automatic test_wb_done_at_limit();
      run(3'd1, 32'h0000_5800, 1'b1, 2'b00, 1, 4);
      tests++; if (wb_cnt !== 4 || err_cnt !== 0 || upd_cnt !== 1 || upd_val !== 2'b10) begin
         fails++; $display("FAIL lim got wb=%0d err=%0d upd=%0d st=%b want 4/0/1/10", wb_cnt, err_cnt, upd_cnt, upd_val); end
   endtask

   task automatic test_miss_delay();
      run(3'd1, 32'h0000_6000, 1'b0, 2'b00, 5, 0);
      tests++; if (lreq_cnt !== 5 || addr_bad !== 0) begin
         fails++; $display("FAIL miss_lreq got %0d bad=%0d want 5/0", lreq_cnt, addr_bad); end
      tests++; if (upd_cnt !== 0 || err_cnt !== 0 || res_val !== 2'b00 || res_cyc !== acc + 8) begin
         fails++; $display("FAIL miss_res got upd=%0d err=%0d r=%b cyc=%0d want 0/0/00/8", upd_cnt, err_cnt, res_val, res_cyc - acc); end
   endtask

   task automatic test_reset_mid();
      clr();
      exp_addr = 32'h0000_7000;
      snoop_valid = 1'b1; snoop_op = 3'd1; snoop_addr = exp_addr;
      @(posedge clk); #1;
      snoop_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      tests++; if (snoop_ready !== 1'b1 || lookup_req !== 1'b0) begin
         fails++; $display("FAIL rmid_ready got rdy=%b lreq=%b want 1/0", snoop_ready, lookup_req); end
      lookup_ack = 1'b1; lookup_hit = 1'b1; lookup_state = 2'b01;
      @(posedge clk); #1;
      lookup_ack = 1'b0;
      repeat (6) @(posedge clk); #1;
      tests++; if (res_cnt !== 0 || upd_cnt !== 0 || err_cnt !== 0) begin
         fails++; $display("FAIL rmid_quiet got res=%0d upd=%0d err=%0d want 0/0/0", res_cnt, upd_cnt, err_cnt); end
   endtask

   initial begin
      clr();
      repeat (3) @(posedge clk); #1;
      reset = 1'b0;
      test_reset();
      test_read_e();
      test_read_m_wb();
      test_rwim();
      test_errors();
      test_wb_timeout();
      test_wb_done_at_limit();
      test_miss_delay();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
